// File: rtl/imm_encode.sv
// Immediate encoder: packs a signed immediate into I/S/B/J instruction fields and
// range/alignment-checks it, behind a 2-entry output FIFO. Optional round-trip self-check: IMM_ENC_ROUNDTRIP_EN.
module imm_encode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic             out_mism,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0] enc_instr;
  logic        enc_err;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        ready_r;
  logic        push;
  logic        pop;
  logic [31:0] instr0;
  logic [31:0] instr1;
  logic        err0;
  logic        err1;

  // Field packing and range check from the incoming word
  always_comb begin
    enc_instr = in_base;
    enc_err   = 1'b0;
    case (in_fmt)
      2'b00: begin
        enc_instr = (in_base & ~32'hFFF0_0000) | {in_imm[11:0], 20'd0};
        enc_err   = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      2'b01: begin
        enc_instr = (in_base & ~32'hFE00_0F80) | {in_imm[11:5], 13'd0, in_imm[4:0], 7'd0};
        enc_err   = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      2'b10: begin
        enc_instr = (in_base & ~32'hFE00_0F80)
                  | {in_imm[12], in_imm[10:5], 13'd0, in_imm[4:1], in_imm[11], 7'd0};
        enc_err   = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
      end
      2'b11: begin
        enc_instr = (in_base & ~32'hFFFF_F000)
                  | {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'd0};
        enc_err   = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
      end
      default: begin
        enc_instr = in_base;
        enc_err   = 1'b0;
      end
    endcase
  end

  assign push = in_valid && ready_r;
  assign pop  = out_valid && out_ready;

  // Occupancy update; a push at count 2 cannot happen because ready_r is already low
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end else begin
      count_next = count;
    end
  end

`ifdef IMM_ENC_ROUNDTRIP_EN
  logic [31:0] imm0;
  logic [31:0] imm1;
  logic [1:0]  fmt0;
  logic [1:0]  fmt1;
  logic [31:0] rext;

  // Re-extend the head entry's immediate with the core's extender rules
  always_comb begin
    rext = 32'd0;
    case (fmt0)
      2'b00:   rext = {{20{instr0[31]}}, instr0[31:20]};
      2'b01:   rext = {{20{instr0[31]}}, instr0[31:25], instr0[11:7]};
      2'b10:   rext = {{19{instr0[31]}}, instr0[31], instr0[7], instr0[30:25], instr0[11:8], 1'b0};
      2'b11:   rext = {{11{instr0[31]}}, instr0[31], instr0[19:12], instr0[20], instr0[30:21], 1'b0};
      default: rext = 32'd0;
    endcase
  end

  assign out_mism = out_valid && (rext != imm0) && !err0;

  // Round-trip side data travels with the FIFO entries
  always_ff @(posedge clk) begin
    if (reset) begin
      imm0 <= 32'd0;
      imm1 <= 32'd0;
      fmt0 <= 2'd0;
      fmt1 <= 2'd0;
    end else begin
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        imm0 <= in_imm;
        fmt0 <= in_fmt;
      end else if (pop) begin
        imm0 <= imm1;
        fmt0 <= fmt1;
      end
      if (push && count == 2'd1 && !pop) begin
        imm1 <= in_imm;
        fmt1 <= in_fmt;
      end
    end
  end
`else
  assign out_mism = 1'b0;
`endif

  // FIFO storage, occupancy, registered in_ready and saturating error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      ready_r   <= 1'b1;
      instr0    <= 32'd0;
      instr1    <= 32'd0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      err_count <= '0;
    end else begin
      count   <= count_next;
      ready_r <= (count_next < 2'd2);
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        instr0 <= enc_instr;
        err0   <= enc_err;
      end else if (pop) begin
        instr0 <= instr1;
        err0   <= err1;
      end
      if (push && count == 2'd1 && !pop) begin
        instr1 <= enc_instr;
        err1   <= enc_err;
      end
      if (push && enc_err && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = (count != 2'd0);
  assign out_instr = instr0;
  assign out_err   = err0;

endmodule

// File: tb/tb_imm_encode.sv
// Scoreboard bench for imm_encode: random and directed words checked against a
// bit-mapping reference model; a separate monitor pops expectations as the DUT emits.
module tb_imm_encode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_fmt = 2'd0;
  logic [31:0] in_imm = 32'd0;
  logic [31:0] in_base = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_mism;
  logic [15:0] err_count;

  int compared = 0;
  int mismatched = 0;
  int exp_errs = 0;
  int bp_mode = 0;  // 0: always ready, 1: never ready, 2: random
  logic [32:0] sb_q[$];

  imm_encode #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .out_mism(out_mism), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Which immediate bit lands in instruction bit p for a format, -1 if base bit is kept
  function automatic int imm_idx(input logic [1:0] f, input int p);
    case (f)
      2'd0: return (p >= 20) ? p - 20 : -1;
      2'd1: begin
        if (p >= 25) return p - 20;
        if (p >= 7 && p <= 11) return p - 7;
        return -1;
      end
      2'd2: begin
        if (p == 31) return 12;
        if (p >= 25 && p <= 30) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        if (p == 7) return 11;
        return -1;
      end
      default: begin
        if (p == 31) return 20;
        if (p >= 21 && p <= 30) return p - 20;
        if (p == 20) return 11;
        if (p >= 12 && p <= 19) return p;
        return -1;
      end
    endcase
  endfunction

  function automatic logic [32:0] model(input logic [1:0] f, input logic [31:0] imm,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    int          v;
    int          idx;
    v = $signed(imm);
    for (int p = 0; p < 32; p++) begin
      idx = imm_idx(f, p);
      r[p] = (idx >= 0) ? imm[idx] : b[p];
    end
    case (f)
      2'd0, 2'd1: e = (v < -2048) || (v > 2047);
      2'd2:       e = (imm[0] == 1'b1) || (v < -4096) || (v > 4095);
      default:    e = (imm[0] == 1'b1) || (v < -(1 << 20)) || (v > (1 << 20) - 1);
    endcase
    return {e, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Offer one word, wait (bounded) for acceptance, then record its expected result
  task automatic send_exp(input logic [1:0] f, input logic [31:0] imm, input logic [31:0] b,
                          input logic [32:0] exp);
    int n = 0;
    in_valid = 1'b1; in_fmt = f; in_imm = imm; in_base = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        compared++; mismatched++;
        $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        @(posedge clk); #1 in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    sb_q.push_back(exp);
    if (exp[32]) exp_errs++;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [31:0] imm, input logic [31:0] b);
    send_exp(f, imm, b, model(f, imm, b));
  endtask

  task automatic drain();
    int n = 0;
    bp_mode = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  function automatic logic [31:0] sat_errs();
    return (exp_errs > 65535) ? 32'd65535 : exp_errs;
  endfunction

  // out_ready driver, applied later in the cycle than the stimulus writes bp_mode
  initial forever begin
    @(posedge clk); #2;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops and compares on every output handshake
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (!reset && out_valid) begin
      compared++;
      if (out_mism !== 1'b0) begin
        mismatched++;
        $display("FAIL out_mism: got %b expected 0", out_mism);
      end
    end
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_out: got %h expected no output", out_instr);
      end else begin
        e = sb_q.pop_front();
        chk("out_instr", out_instr, e[31:0]);
        chk("out_err", {31'd0, out_err}, {31'd0, e[32]});
      end
    end
  end

  initial begin
    logic [1:0]  f;
    logic [31:0] imm;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_out_mism", {31'd0, out_mism}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed vectors
    send_exp(2'b00, 32'hFFFF_FFFF, 32'h0000_0013, {1'b0, 32'hFFF0_0013});
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    send_exp(2'b01, 32'h0000_07FF, 32'h0000_2023, {1'b0, 32'h7E00_2FA3});
    send_exp(2'b10, 32'hFFFF_FFFC, 32'h0000_0063, {1'b0, 32'hFE00_0EE3});
    send_exp(2'b11, 32'h0000_0800, 32'h0000_006F, {1'b0, 32'h0010_006F});
    send(2'b10, 32'h0000_0003, 32'h0000_0063);
    chk("err_count_b_misalign", {16'd0, err_count}, 32'd1);
    send_exp(2'b00, 32'h0000_0800, 32'h0000_0013, {1'b1, 32'h8000_0013});
    chk("err_count_i_range", {16'd0, err_count}, 32'd2);
    drain();

    // Backpressure: two fill the buffer, third stalls until out_ready returns
    bp_mode = 1;
    @(posedge clk); #1;
    send(2'b00, 32'h0000_0001, 32'h0000_0013);
    send(2'b01, 32'h0000_0002, 32'h0000_2023);
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    fork
      send(2'b11, 32'h0000_0004, 32'h0000_006F);
      begin
        @(negedge clk);
        chk("bp_third_stalled", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 bp_mode = 0;
      end
    join
    drain();

    // Randomized words with random backpressure
    bp_mode = 2;
    for (int i = 0; i < 400; i++) begin
      f = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        default: begin
          case (f)
            2'd0, 2'd1: imm = $urandom_range(0, 4095) - 2048;
            2'd2:       imm = ($urandom_range(0, 4095) - 2048) * 2;
            default:    imm = ($urandom_range(0, (1 << 20) - 1) - (1 << 19)) * 2;
          endcase
        end
      endcase
      send(f, imm, $urandom);
    end
    drain();
    chk("rand_err_count", {16'd0, err_count}, sat_errs());

    // Reset with two entries buffered
    bp_mode = 1;
    @(posedge clk); #1;
    send(2'b00, 32'h0000_0010, 32'h0000_0013);
    send(2'b00, 32'h0000_0800, 32'h0000_0013);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb_q.delete();
    exp_errs = 0;
    bp_mode = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_err_count", {16'd0, err_count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Saturation of the error counter
    for (int i = 0; i < 65534; i++) send(2'b10, 32'h0000_0003, 32'h0000_0063);
    drain();
    chk("sat_preload", {16'd0, err_count}, sat_errs());
    send(2'b00, 32'h0001_0000, 32'h0000_0013);
    send(2'b11, 32'h0000_0001, 32'h0000_006F);
    drain();
    chk("sat_reach", {16'd0, err_count}, 32'd65535);
    send(2'b01, 32'h8000_0000, 32'h0000_2023);
    send(2'b00, 32'h0000_0005, 32'h0000_0013);
    drain();
    chk("sat_hold", {16'd0, err_count}, 32'd65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
